route_lookup_arbiter: RTL and testbench
=======================================

ROUTE_LOOKUP_ARBITER -- requirements
Module: route_lookup_arbiter

Interface
REQ-001 Parameter PORTS_CNT, default 5, SHALL set the number of requesting input ports.
REQ-002 Parameter LOG_PORTS_CNT, default 3, SHALL set the width of one routing-table entry (output-port index).
REQ-003 Parameter ADDR_W, default 10, SHALL set the destination-address width.
REQ-004 Parameter TABLE_DEPTH, default 1000, SHALL set the number of routing-table entries.
REQ-005 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the reset: asynchronous and active-high.
REQ-007 req_valid  input  PORTS_CNT  SHALL flag a pending lookup per port; bit i belongs to port i.
REQ-008 req_dest  input  PORTS_CNT*ADDR_W  SHALL carry each port's destination; port i occupies bits [i*ADDR_W : (i+1)*ADDR_W-1], MSB-first.
REQ-009 req_grant  output  PORTS_CNT  SHALL pulse one bit for one cycle when that port's request is accepted.
REQ-010 rsp_valid  output  PORTS_CNT  SHALL flag a held lookup result for the granted port.
REQ-011 rsp_port  output  LOG_PORTS_CNT  SHALL carry the looked-up output-port index.
REQ-012 rsp_err  output  1  SHALL flag that the looked-up destination was >= TABLE_DEPTH.
REQ-013 rsp_ack  input  PORTS_CNT  SHALL acknowledge the result; only the bit matching the active rsp_valid bit is honoured.
REQ-014 cfg_we, cfg_addr[ADDR_W], cfg_port[LOG_PORTS_CNT]  input  SHALL form the table write port.
REQ-015 cfg_err  output  1  SHALL pulse one cycle when a write addresses >= TABLE_DEPTH.
REQ-016 busy  output  1  SHALL be high whenever the FSM is not IDLE.

Function
REQ-017 Block SHALL own a TABLE_DEPTH x LOG_PORTS_CNT register table and serialize all lookups into it: at most one lookup in flight.
REQ-018 FSM states SHALL be IDLE, READ, RESP.
REQ-019 IDLE: with any req_valid high, at the edge the block SHALL latch winner index and its req_dest, set req_grant[winner]=1, and go to READ; else stay IDLE.
REQ-020 Winner SHALL be chosen round-robin: first set req_valid bit at or after rr_ptr, wrapping PORTS_CNT-1 -> 0; rr_ptr SHALL become winner+1 (mod PORTS_CNT) at grant.
REQ-021 req_grant SHALL be high only during the READ cycle; req_valid/req_dest SHALL be ignored outside IDLE.
REQ-022 READ: at the edge rsp_port SHALL load table[latched dest], rsp_valid[winner]=1, rsp_err=0; go to RESP.
REQ-023 Destination >= TABLE_DEPTH: rsp_port SHALL be 0 and rsp_err=1, response otherwise normal.
REQ-024 RESP: rsp_valid, rsp_port, rsp_err SHALL hold stable until rsp_ack[winner]=1; at that edge they SHALL clear and the FSM return to IDLE.
REQ-025 Request-to-result latency SHALL be 2 cycles (grant visible cycle 1, result cycle 2); peak throughput one lookup per 3 cycles with same-cycle ack.
REQ-026 cfg_we SHALL be accepted in every state, writing cfg_port to table[cfg_addr] at the edge; out-of-range writes SHALL change nothing and pulse cfg_err next cycle.
REQ-027 Write and READ to the same entry in the same cycle: lookup SHALL return the pre-write value.
REQ-028 rsp_ack bits for non-winning ports, or in IDLE/READ, SHALL be ignored.

Reset
REQ-029 rst high SHALL immediately force: state IDLE, rr_ptr 0, req_grant 0, rsp_valid 0, rsp_port 0, rsp_err 0, cfg_err 0, busy 0, every table entry 0.
REQ-030 rst asserted mid-lookup SHALL abandon it; no grant or response for it SHALL appear after release.

Verification
REQ-031 Write table[7]=3, port 2 requests dest 7 -> req_grant=00100 next cycle, rsp_valid=00100 with rsp_port=3 the cycle after, held until rsp_ack[2].
REQ-032 All 5 ports request continuously, immediate acks -> grant order 0,1,2,3,4,0 with no port granted twice before all others.
REQ-033 Request dest 1000 -> rsp_err=1, rsp_port=0; cfg write to addr 1023 -> cfg_err one-cycle pulse, no table change.
REQ-034 table[5]=1, write table[5]=6 in the READ cycle of a dest-5 lookup -> rsp_port=1; next dest-5 lookup -> 6.
REQ-035 Assert rst during RESP -> all outputs 0 immediately, table cleared, new request after release looks up 0 and grants port by rr_ptr=0.

Source files
------------

// File: rtl/route_lookup_arbiter.sv
// Round-robin arbiter that serializes per-port route lookups into a shared,
// software-written table of output-port indices; one lookup in flight at a time.
module route_lookup_arbiter #(
  parameter int PORTS_CNT     = 5,
  parameter int LOG_PORTS_CNT = 3,
  parameter int ADDR_W        = 10,
  parameter int TABLE_DEPTH   = 1000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [PORTS_CNT-1:0]          req_valid,
  input  logic [PORTS_CNT*ADDR_W-1:0]   req_dest,
  output logic [PORTS_CNT-1:0]          req_grant,
  output logic [PORTS_CNT-1:0]          rsp_valid,
  output logic [LOG_PORTS_CNT-1:0]      rsp_port,
  output logic                          rsp_err,
  input  logic [PORTS_CNT-1:0]          rsp_ack,
  input  logic                          cfg_we,
  input  logic [ADDR_W-1:0]             cfg_addr,
  input  logic [LOG_PORTS_CNT-1:0]      cfg_port,
  output logic                          cfg_err,
  output logic                          busy
);

  localparam int              PTR_W = (PORTS_CNT > 1) ? $clog2(PORTS_CNT) : 1;
  localparam logic [ADDR_W:0] DEPTH = (ADDR_W + 1)'(TABLE_DEPTH);

  typedef enum logic [1:0] {IDLE, READ, RESP} state_t;

  state_t                   state;
  logic [PTR_W-1:0]         rr_ptr;
  logic [PTR_W-1:0]         winner_q;
  logic [ADDR_W-1:0]        dest_q;
  logic [LOG_PORTS_CNT-1:0] table_q [TABLE_DEPTH];

  logic                     pick_found;
  logic [PTR_W-1:0]         pick_idx;
  logic [ADDR_W-1:0]        pick_dest;
  logic [LOG_PORTS_CNT-1:0] rd_data;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < DEPTH;
  endfunction

  // Port index base+off, wrapped modulo PORTS_CNT.
  function automatic logic [PTR_W-1:0] wrap_add(input logic [PTR_W-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= PORTS_CNT) sum -= PORTS_CNT;
    return PTR_W'(sum);
  endfunction

  function automatic logic [PORTS_CNT-1:0] onehot(input logic [PTR_W-1:0] idx);
    logic [PORTS_CNT-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

  // NOTE: every always_comb output gets a default before any branch, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int off = 0; off < PORTS_CNT; off++) begin
      if (!pick_found && req_valid[wrap_add(rr_ptr, off)]) begin
        pick_found = 1'b1;
        pick_idx   = wrap_add(rr_ptr, off);
      end
    end
  end

  assign pick_dest = req_dest[int'(pick_idx) * ADDR_W +: ADDR_W];
  assign rd_data   = in_range(dest_q) ? table_q[dest_q] : '0;
  assign busy      = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments; this is also what makes
  // a READ that coincides with a cfg write to the same entry see the old value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      winner_q  <= '0;
      dest_q    <= '0;
      req_grant <= '0;
      rsp_valid <= '0;
      rsp_port  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            winner_q  <= pick_idx;
            dest_q    <= pick_dest;
            req_grant <= onehot(pick_idx);
            rr_ptr    <= wrap_add(pick_idx, 1);
            state     <= READ;
          end
        end
        READ: begin
          req_grant <= '0;
          rsp_valid <= onehot(winner_q);
          rsp_port  <= rd_data;
          rsp_err   <= !in_range(dest_q);
          state     <= RESP;
        end
        RESP: begin
          // Only the winner's ack bit retires the held result.
          if (rsp_ack[winner_q]) begin
            rsp_valid <= '0;
            rsp_port  <= '0;
            rsp_err   <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the table is flop-based and cleared by reset because a post-reset lookup
  // must return 0; a RAM macro could not offer that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < TABLE_DEPTH; i++) table_q[i] <= '0;
      cfg_err <= 1'b0;
    end else begin
      cfg_err <= cfg_we && !in_range(cfg_addr);
      if (cfg_we && in_range(cfg_addr)) table_q[cfg_addr] <= cfg_port;
    end
  end

endmodule

// File: tb/tb_route_lookup_arbiter.sv
// Scoreboard bench for route_lookup_arbiter: stimulus pushes expected grants,
// responses and cfg errors; a negedge monitor pops and compares them.
module tb_route_lookup_arbiter;

  localparam int P  = 5;
  localparam int LP = 3;
  localparam int AW = 10;
  localparam int TD = 1000;

  logic              clk = 1'b0;
  logic              rst;
  logic [P-1:0]      req_valid;
  logic [P*AW-1:0]   req_dest;
  logic [P-1:0]      req_grant;
  logic [P-1:0]      rsp_valid;
  logic [LP-1:0]     rsp_port;
  logic              rsp_err;
  logic [P-1:0]      rsp_ack;
  logic              cfg_we;
  logic [AW-1:0]     cfg_addr;
  logic [LP-1:0]     cfg_port;
  logic              cfg_err;
  logic              busy;

  route_lookup_arbiter #(.PORTS_CNT(P), .LOG_PORTS_CNT(LP), .ADDR_W(AW), .TABLE_DEPTH(TD)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dest(req_dest), .req_grant(req_grant),
    .rsp_valid(rsp_valid), .rsp_port(rsp_port), .rsp_err(rsp_err), .rsp_ack(rsp_ack),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_port(cfg_port), .cfg_err(cfg_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct { int port; int cyc; } grant_t;
  typedef struct { int port; int rport; int err; int cyc; int hold; } rsp_t;

  grant_t exp_grant[$];
  rsp_t   exp_rsp[$];
  int     exp_cfg[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- monitor ----------------
  rsp_t cur;
  bit   active = 1'b0;
  int   run_len = 0;

  always @(negedge clk) begin
    if (req_grant != '0) begin
      if (exp_grant.size() == 0) check("grant_unexpected", 32'(req_grant), 0);
      else begin
        grant_t g;
        g = exp_grant.pop_front();
        check("grant_vec", 32'(req_grant), 32'(1) << g.port);
        if (g.cyc >= 0) check("grant_cycle", cyc, g.cyc);
      end
    end
    if (rsp_valid != '0) begin
      if (!active) begin
        if (exp_rsp.size() == 0) check("rsp_unexpected", 32'(rsp_valid), 0);
        else begin
          cur     = exp_rsp.pop_front();
          active  = 1'b1;
          run_len = 0;
          check("rsp_cycle", cyc, cur.cyc);
        end
      end
      if (active) begin
        run_len++;
        check("rsp_valid", 32'(rsp_valid), 32'(1) << cur.port);
        check("rsp_port", 32'(rsp_port), cur.rport);
        check("rsp_err", 32'(rsp_err), cur.err);
      end
    end else if (active) begin
      check("rsp_hold_len", run_len, cur.hold);
      active = 1'b0;
    end
    if (cfg_err) begin
      if (exp_cfg.size() == 0) check("cfg_err_unexpected", 32'(cfg_err), 0);
      else check("cfg_err_cycle", cyc, exp_cfg.pop_front());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_dest(input int port, input int dest);
    req_dest[port*AW +: AW] = AW'(dest);
  endtask

  task automatic cfg_write(input int addr, input int port);
    cfg_we   = 1'b1;
    cfg_addr = AW'(addr);
    cfg_port = LP'(port);
    if (addr >= TD) exp_cfg.push_back(cyc + 1);
    step();
    cfg_we = 1'b0;
  endtask

  // Starts in IDLE just after an edge; returns in IDLE just after the ack edge.
  task automatic lookup(input int port, input int dest, input int exp_port, input int exp_err,
                        input int ack_delay, input logic [P-1:0] extra,
                        input bit mid_wr, input int wr_addr, input int wr_port);
    req_valid = (P'(1) << port) | extra;
    set_dest(port, dest);
    exp_grant.push_back('{port: port, cyc: cyc + 1});
    exp_rsp.push_back('{port: port, rport: exp_port, err: exp_err, cyc: cyc + 2, hold: ack_delay + 1});
    step();
    // READ: new requests and dest changes must be ignored
    check("busy_in_read", 32'(busy), 1);
    req_valid = '1;
    req_dest  = '1;
    if (mid_wr) begin
      cfg_we   = 1'b1;
      cfg_addr = AW'(wr_addr);
      cfg_port = LP'(wr_port);
    end
    step();
    req_valid = '0;
    cfg_we    = 1'b0;
    for (int i = 0; i < ack_delay; i++) begin
      rsp_ack = ~(P'(1) << port);
      step();
    end
    rsp_ack = '1;
    step();
    rsp_ack = '0;
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_req_grant"}, 32'(req_grant), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_port"},  32'(rsp_port), 0);
    check({tag, "_rsp_err"},   32'(rsp_err), 0);
    check({tag, "_cfg_err"},   32'(cfg_err), 0);
    check({tag, "_busy"},      32'(busy), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin
    int c0;
    rst = 1'b1; req_valid = '0; req_dest = '0; rsp_ack = '0;
    cfg_we = 1'b0; cfg_addr = '0; cfg_port = '0;
    step(); step();
    check_outputs_zero("reset");
    rst = 1'b0;
    step();

    // Basic lookup with held result and ignored wrong-port acks; rr_ptr -> 3
    cfg_write(7, 3);
    lookup(2, 7, 3, 0, 3, '0, 1'b0, 0, 0);

    // Out-of-range destination and config writes
    lookup(2, 1000, 0, 1, 0, '0, 1'b0, 0, 0);
    cfg_write(1023, 5);
    cfg_write(1000, 2);
    cfg_write(999, 7);
    lookup(0, 999, 7, 0, 1, '0, 1'b0, 0, 0);
    lookup(1, 23, 0, 0, 0, '0, 1'b0, 0, 0);

    // Write during READ returns the pre-write value; rr_ptr ends at 0
    cfg_write(5, 1);
    lookup(3, 5, 1, 0, 0, '0, 1'b1, 5, 6);
    lookup(4, 5, 6, 0, 0, '0, 1'b0, 0, 0);

    // All ports requesting continuously with immediate acks
    for (int i = 0; i < P; i++) cfg_write(10 + i, i + 2);
    req_valid = '1;
    for (int i = 0; i < P; i++) set_dest(i, 10 + i);
    rsp_ack = '1;
    c0 = cyc;
    for (int k = 0; k < 6; k++) begin
      exp_grant.push_back('{port: k % P, cyc: c0 + 1 + 3*k});
      exp_rsp.push_back('{port: k % P, rport: (k % P) + 2, err: 0, cyc: c0 + 2 + 3*k, hold: 1});
    end
    repeat (16) step();
    req_valid = '0;
    step(); step();
    rsp_ack = '0;

    // Reset during RESP abandons the lookup and clears the table
    req_valid = P'(1) << 1;
    set_dest(1, 7);
    exp_grant.push_back('{port: 1, cyc: cyc + 1});
    exp_rsp.push_back('{port: 1, rport: 3, err: 0, cyc: cyc + 2, hold: 1});
    step();
    req_valid = '0;
    step();
    #5;
    rst = 1'b1;
    #1;
    check_outputs_zero("mid_reset");
    step();
    rst = 1'b0;
    repeat (3) step();

    lookup(1, 7, 0, 0, 0, P'(1) << 3, 1'b0, 0, 0);
    lookup(2, 5, 0, 0, 0, '0, 1'b0, 0, 0);
    lookup(0, 999, 0, 0, 0, '0, 1'b0, 0, 0);

    repeat (3) step();
    check("grant_queue_empty", exp_grant.size(), 0);
    check("rsp_queue_empty", exp_rsp.size(), 0);
    check("cfg_queue_empty", exp_cfg.size(), 0);
    check("rsp_run_closed", 32'(active), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
